// File: rtl/demosaic_pkg.sv
// rtl/demosaic_pkg.sv - shared types and width helpers for the demosaic frame sequencer
package demosaic_pkg;

   typedef enum logic [1:0] {IDLE, ACTIVE, DROP, FLUSH} state_t;

   localparam int PIX_W = 8;

   // A counter over n positions needs at least one bit even when n == 1.
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int col_w(input int ncol);
      return cnt_w(ncol);
   endfunction

   function automatic int row_w(input int nrows);
      return cnt_w(nrows);
   endfunction

endpackage

// File: rtl/demosaic_line_cnt.sv
// rtl/demosaic_line_cnt.sv - column/row position counter with wrap and last-pixel flags
module demosaic_line_cnt
   import demosaic_pkg::*;
#(
   parameter  int Nrows = 349,
   parameter  int Ncol  = 349,
   localparam int CW    = col_w(Ncol),
   localparam int RW    = row_w(Nrows)
)
(
   input  logic          clk,
   input  logic          rst,
   input  logic          i_clr,
   input  logic          i_inc,
   output logic [CW-1:0] o_col,
   output logic [RW-1:0] o_row,
   output logic          o_col_last,
   output logic          o_row_last
);

   logic [CW-1:0] r_col;
   logic [RW-1:0] r_row;
   logic [CW-1:0] w_col_eff;
   logic [RW-1:0] w_row_eff;
   logic          w_col_last;
   logic          w_row_last;

   // Last flags describe the position of the current beat, which is (0,0) when clearing.
   assign w_col_eff  = i_clr ? '0 : r_col;
   assign w_row_eff  = i_clr ? '0 : r_row;
   assign w_col_last = (w_col_eff == CW'(Ncol - 1));
   assign w_row_last = (w_row_eff == RW'(Nrows - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_col <= '0;
         r_row <= '0;
      end else if (i_inc) begin
         if (w_col_last) begin
            r_col <= '0;
            r_row <= w_row_last ? '0 : w_row_eff + 1'b1;
         end else begin
            r_col <= w_col_eff + 1'b1;
            r_row <= w_row_eff;
         end
      end else if (i_clr) begin
         r_col <= '0;
         r_row <= '0;
      end
   end

   assign o_col      = r_col;
   assign o_row      = r_row;
   assign o_col_last = w_col_last;
   assign o_row_last = w_row_last;

endmodule

// File: rtl/demosaic_frame_ctrl.sv
// rtl/demosaic_frame_ctrl.sv - frame sequencer ahead of the 3x3 demosaic kernel; DEMOSAIC_FLUSH_EN adds a zero flush line
module demosaic_frame_ctrl
   import demosaic_pkg::*;
#(
   parameter int Nrows = 349,
   parameter int Ncol  = 349
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             s_axis_tvalid,
   input  logic             s_axis_tuser,
   input  logic             s_axis_tlast,
   input  logic [PIX_W-1:0] s_axis_tdata,
   output logic             m_axis_tvalid,
   output logic             m_axis_tuser,
   output logic             m_axis_tlast,
   output logic [PIX_W-1:0] m_axis_tdata,
   output logic             frame_done,
   output logic             err_short,
   output logic             err_long,
   output logic             err_sof,
   input  logic             err_clr,
   output logic [15:0]      frame_cnt
);

   localparam int CW = col_w(Ncol);
   localparam int RW = row_w(Nrows);

   state_t           r_state;
   logic             r_tvalid, r_tuser, r_tlast, r_done;
   logic             r_err_short, r_err_long, r_err_sof;
   logic [PIX_W-1:0] r_tdata;
   logic [15:0]      r_frame_cnt;

   logic [CW-1:0]    w_col;
   logic [RW-1:0]    w_row;
   logic             w_col_last, w_row_last;
   logic             w_sof, w_start, w_beat, w_cnt_inc;
   logic             w_fwd, w_fwd_last, w_zero_beat, w_done;
   logic             w_set_short, w_set_long, w_set_sof;
   state_t           w_next;

   assign w_sof   = s_axis_tvalid & s_axis_tuser;
   assign w_start = w_sof & enable;
   // A beat is framed either as the first pixel of a new frame or as a continuation in ACTIVE.
   assign w_beat  = w_start | (s_axis_tvalid & ~s_axis_tuser & (r_state == ACTIVE));

   demosaic_line_cnt #(.Nrows(Nrows), .Ncol(Ncol)) u_line_cnt (
      .clk        (clk),
      .rst        (rst),
      .i_clr      (w_start),
      .i_inc      (w_cnt_inc),
      .o_col      (w_col),
      .o_row      (w_row),
      .o_col_last (w_col_last),
      .o_row_last (w_row_last)
   );

   always_comb begin
      w_next      = r_state;
      w_cnt_inc   = 1'b0;
      w_fwd       = 1'b0;
      w_fwd_last  = 1'b0;
      w_zero_beat = 1'b0;
      w_done      = 1'b0;
      w_set_short = 1'b0;
      w_set_long  = 1'b0;
      w_set_sof   = 1'b0;

      if (w_sof) begin
         if (r_state == ACTIVE && (w_col != '0 || w_row != '0))
            w_set_sof = 1'b1;
`ifdef DEMOSAIC_FLUSH_EN
         if (r_state == FLUSH)
            w_set_sof = 1'b1;
`endif
         if (!enable && r_state != DROP)
            w_next = (r_state == ACTIVE) ? DROP : IDLE;
      end

      if (w_beat) begin
         w_next = ACTIVE;
         if (w_col_last && s_axis_tlast) begin
            w_fwd      = 1'b1;
            w_fwd_last = 1'b1;
            w_cnt_inc  = 1'b1;
            if (w_row_last) begin
`ifdef DEMOSAIC_FLUSH_EN
               w_next = FLUSH;
`else
               w_done = 1'b1;
               w_next = IDLE;
`endif
            end
         end else if (w_col_last) begin
            w_set_long = 1'b1;
            w_next     = DROP;
         end else if (s_axis_tlast) begin
            w_set_short = 1'b1;
            w_next      = DROP;
         end else begin
            w_fwd     = 1'b1;
            w_cnt_inc = 1'b1;
         end
      end
`ifdef DEMOSAIC_FLUSH_EN
      // Flush beats borrow only idle input slots so the source never needs to stall.
      else if (r_state == FLUSH && !s_axis_tvalid) begin
         w_zero_beat = 1'b1;
         w_cnt_inc   = 1'b1;
         if (w_col_last) begin
            w_fwd_last = 1'b1;
            w_done     = 1'b1;
            w_next     = IDLE;
         end
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_tvalid    <= 1'b0;
         r_tuser     <= 1'b0;
         r_tlast     <= 1'b0;
         r_tdata     <= '0;
         r_done      <= 1'b0;
         r_err_short <= 1'b0;
         r_err_long  <= 1'b0;
         r_err_sof   <= 1'b0;
         r_frame_cnt <= '0;
      end else begin
         r_state     <= w_next;
         r_tvalid    <= w_fwd | w_zero_beat;
         r_tuser     <= w_fwd & w_start;
         r_tlast     <= w_fwd_last;
         r_tdata     <= w_fwd ? s_axis_tdata : '0;
         r_done      <= w_done;
         r_err_short <= w_set_short | (r_err_short & ~err_clr);
         r_err_long  <= w_set_long  | (r_err_long  & ~err_clr);
         r_err_sof   <= w_set_sof   | (r_err_sof   & ~err_clr);
         if (w_done)
            r_frame_cnt <= r_frame_cnt + 16'd1;
      end
   end

   assign m_axis_tvalid = r_tvalid;
   assign m_axis_tuser  = r_tuser;
   assign m_axis_tlast  = r_tlast;
   assign m_axis_tdata  = r_tdata;
   assign frame_done    = r_done;
   assign err_short     = r_err_short;
   assign err_long      = r_err_long;
   assign err_sof       = r_err_sof;
   assign frame_cnt     = r_frame_cnt;

endmodule

// File: tb/tb_demosaic_frame_ctrl.sv
// tb/tb_demosaic_frame_ctrl.sv - self-checking bench for demosaic_frame_ctrl (honours DEMOSAIC_FLUSH_EN)
module tb_demosaic_frame_ctrl;

   localparam int NROWS = 4;
   localparam int NCOL  = 5;
   localparam int NPIX  = NROWS * NCOL;
`ifdef DEMOSAIC_FLUSH_EN
   localparam bit FLUSH_EN = 1'b1;
`else
   localparam bit FLUSH_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst, enable, s_tvalid, s_tuser, s_tlast, err_clr;
   logic [7:0]  s_tdata;
   logic        m_tvalid, m_tuser, m_tlast, frame_done, err_short, err_long, err_sof;
   logic [7:0]  m_tdata;
   logic [15:0] frame_cnt;

   int n_vec = 0;
   int n_err = 0;
   int exp_cnt = 0;

   // Reference model: position is a flat pixel index within the frame.
   bit          m_in;
   int          m_idx;
   int          m_flush;
   logic [15:0] m_cnt;
   bit          m_es, m_el, m_ef;

   always #5 clk = ~clk;

   demosaic_frame_ctrl #(.Nrows(NROWS), .Ncol(NCOL)) dut (
      .clk           (clk),
      .rst           (rst),
      .enable        (enable),
      .s_axis_tvalid (s_tvalid),
      .s_axis_tuser  (s_tuser),
      .s_axis_tlast  (s_tlast),
      .s_axis_tdata  (s_tdata),
      .m_axis_tvalid (m_tvalid),
      .m_axis_tuser  (m_tuser),
      .m_axis_tlast  (m_tlast),
      .m_axis_tdata  (m_tdata),
      .frame_done    (frame_done),
      .err_short     (err_short),
      .err_long      (err_long),
      .err_sof       (err_sof),
      .err_clr       (err_clr),
      .frame_cnt     (frame_cnt)
   );

   function automatic logic [30:0] dut_pack();
      return {m_tvalid, m_tuser, m_tlast, m_tdata, frame_done, err_short, err_long, err_sof, frame_cnt};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model(input bit r, input bit en, input bit vv, input bit uu, input bit ll,
                        input logic [7:0] dd, input bit clr, output logic [30:0] e);
      bit ov, ou, ol, odone, s_es, s_el, s_ef;
      logic [7:0] odat;
      int col;
      ov = 0; ou = 0; ol = 0; odone = 0; s_es = 0; s_el = 0; s_ef = 0; odat = 8'h00;
      if (r) begin
         m_in = 0; m_idx = 0; m_flush = -1; m_cnt = 16'd0;
         m_es = 0; m_el = 0; m_ef = 0;
         e = '0;
         return;
      end
      if (vv && uu) begin
         if (m_in && m_idx != 0) s_ef = 1;
         if (m_flush >= 0) s_ef = 1;
         m_flush = -1;
         m_in = 0;
         if (en) begin
            m_in = 1;
            m_idx = 0;
         end
      end
      if (vv && m_in) begin
         col = m_idx % NCOL;
         if (col == NCOL - 1 && !ll) begin
            s_el = 1; m_in = 0;
         end else if (col != NCOL - 1 && ll) begin
            s_es = 1; m_in = 0;
         end else begin
            ov = 1; odat = dd; ou = (m_idx == 0); ol = (col == NCOL - 1);
            m_idx++;
            if (m_idx == NPIX) begin
               m_in = 0;
               if (FLUSH_EN) m_flush = 0;
               else odone = 1;
            end
         end
      end else if (!vv && m_flush >= 0) begin
         ov = 1;
         ol = (m_flush == NCOL - 1);
         m_flush++;
         if (m_flush == NCOL) begin
            odone = 1;
            m_flush = -1;
         end
      end
      if (odone) m_cnt = m_cnt + 16'd1;
      m_es = s_es | (m_es & !clr);
      m_el = s_el | (m_el & !clr);
      m_ef = s_ef | (m_ef & !clr);
      e = {ov, ou, ol, odat, odone, m_es, m_el, m_ef, m_cnt};
   endtask

   task automatic step(input bit r, input bit en, input bit vv, input bit uu, input bit ll,
                       input logic [7:0] dd, input bit clr);
      logic [30:0] e;
      @(negedge clk);
      rst = r; enable = en; s_tvalid = vv; s_tuser = uu; s_tlast = ll; s_tdata = dd; err_clr = clr;
      model(r, en, vv, uu, ll, dd, clr, e);
      @(posedge clk);
      #1;
      check("model", {1'b0, dut_pack()}, {1'b0, e});
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(0, 1, 0, 0, 0, 8'h00, 0);
   endtask

   task automatic beat(input bit en, input int i, input bit uu);
      step(0, en, 1, uu, (i % NCOL == NCOL - 1), 8'($urandom), 0);
   endtask

   task automatic send_frame(input bit en, input int gap_max);
      for (int i = 0; i < NPIX; i++) begin
         int gn;
         gn = $urandom_range(gap_max, 0);
         idle(gn);
         beat(en, i, (i == 0));
      end
   endtask

   typedef struct {
      logic [7:0] d;
      logic       u, l;
      logic       ev, eu, el, edone;
      logic [7:0] ed;
   } vec_t;

   vec_t tbl[NPIX];

   initial begin
      rst = 1; enable = 0; s_tvalid = 0; s_tuser = 0; s_tlast = 0; s_tdata = 0; err_clr = 0;
      m_in = 0; m_idx = 0; m_flush = -1; m_cnt = 0; m_es = 0; m_el = 0; m_ef = 0;

      for (int i = 0; i < NPIX; i++) begin
         tbl[i].d     = 8'(i * 13 + 7);
         tbl[i].u     = (i == 0);
         tbl[i].l     = (i % NCOL == NCOL - 1);
         tbl[i].ev    = 1'b1;
         tbl[i].eu    = (i == 0);
         tbl[i].el    = (i % NCOL == NCOL - 1);
         tbl[i].ed    = 8'(i * 13 + 7);
         tbl[i].edone = !FLUSH_EN && (i == NPIX - 1);
      end

      for (int k = 0; k < 3; k++) step(1, 0, 0, 0, 0, 8'h00, 0);
      check("reset_state", {1'b0, dut_pack()}, 32'h0);

      // Clean frame from the table.
      for (int i = 0; i < NPIX; i++) begin
         step(0, 1, 1, tbl[i].u, tbl[i].l, tbl[i].d, 0);
         check("t1_beat", {m_tvalid, m_tuser, m_tlast, m_tdata, frame_done},
               {tbl[i].ev, tbl[i].eu, tbl[i].el, tbl[i].ed, tbl[i].edone});
      end
      idle(NCOL + 1);
      exp_cnt++;
      check("t1_cnt", frame_cnt, exp_cnt);

      // Early tlast in row 1, then the rest of the frame must stay silent.
      for (int i = 0; i < 7; i++) beat(1, i, (i == 0));
      step(0, 1, 1, 0, 1, 8'h55, 0);
      check("t2_err_short", err_short, 1);
      check("t2_drop", m_tvalid, 0);
      for (int i = 8; i < NPIX; i++) begin
         beat(1, i, 0);
         check("t2_silent", m_tvalid, 0);
      end
      send_frame(1, 1);
      idle(NCOL + 1);
      exp_cnt++;
      check("t2_cnt", frame_cnt, exp_cnt);

      // Missing tlast at end of row 0, then clear.
      for (int i = 0; i < NCOL - 1; i++) beat(1, i, (i == 0));
      step(0, 1, 1, 0, 0, 8'h66, 0);
      check("t3_err_long", err_long, 1);
      check("t3_drop", m_tvalid, 0);
      idle(2);
      step(0, 1, 0, 0, 0, 8'h00, 1);
      check("t3_clr", {err_short, err_long}, 2'b00);

      // Mid-frame tuser resyncs to a new frame.
      for (int i = 0; i < 2 * NCOL + 3; i++) beat(1, i, (i == 0));
      step(0, 1, 1, 1, 0, 8'h77, 0);
      check("t4_err_sof", err_sof, 1);
      check("t4_restart", {m_tvalid, m_tuser, m_tdata}, {1'b1, 1'b1, 8'h77});
      for (int i = 1; i < NPIX; i++) beat(1, i, 0);
      idle(NCOL + 1);
      exp_cnt++;
      check("t4_cnt", frame_cnt, exp_cnt);

`ifdef DEMOSAIC_FLUSH_EN
      begin
         int nz;
         step(0, 1, 0, 0, 0, 8'h00, 1);
         send_frame(1, 0);
         nz = 0;
         for (int c = 0; c < 8; c++) begin
            bit vv;
            vv = (c % 4 == 3);
            step(0, 1, vv, 0, 0, 8'hAA, 0);
            if (!vv) nz++;
            check("t5_zero_valid", m_tvalid, (!vv && nz <= NCOL));
            if (!vv && nz == NCOL) check("t5_last_done", {m_tlast, frame_done, m_tdata}, {2'b11, 8'h00});
         end
         exp_cnt++;
         check("t5_cnt", frame_cnt, exp_cnt);
         send_frame(1, 0);
         idle(2);
         step(0, 1, 1, 1, 0, 8'h12, 0);
         check("t5_flush_sof", {err_sof, m_tuser}, 2'b11);
         for (int i = 1; i < NPIX; i++) beat(1, i, 0);
         idle(NCOL + 1);
         exp_cnt++;
         check("t5_abandon_cnt", frame_cnt, exp_cnt);
      end
`endif

      // Disabled frame, then reset in the middle of a row.
      for (int i = 0; i < NPIX; i++) begin
         beat(0, i, (i == 0));
         check("t6_disabled", m_tvalid, 0);
      end
      for (int i = 0; i < 2 * NCOL + 2; i++) beat(1, i, (i == 0));
      step(1, 1, 1, 0, 0, 8'h99, 0);
      check("t6_rst", {1'b0, dut_pack()}, 32'h0);
      exp_cnt = 0;
      send_frame(1, 0);
      idle(NCOL + 1);
      exp_cnt++;
      check("t6_after_rst", frame_cnt, exp_cnt);

      // Randomized framing with injected faults against the model.
      for (int f = 0; f < 40; f++) begin
         bit en;
         int kind, where, gn;
         en    = ($urandom_range(9, 0) != 0);
         kind  = $urandom_range(15, 0);
         where = $urandom_range(NPIX - 1, 1);
         if ($urandom_range(24, 0) == 0) step(1, 0, 0, 0, 0, 8'h00, 0);
         for (int i = 0; i < NPIX; i++) begin
            bit uu, ll;
            gn = $urandom_range(2, 0);
            for (int g = 0; g < gn; g++) step(0, en, 0, 0, 0, 8'h00, ($urandom_range(7, 0) == 0));
            uu = (i == 0) || (kind == 1 && i == where);
            ll = (i % NCOL == NCOL - 1) ^ (kind == 0 && i == where);
            step(0, en, 1, uu, ll, 8'($urandom), ($urandom_range(7, 0) == 0));
         end
         idle($urandom_range(NCOL + 3, 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
